// File: rtl/vga_term_writer.sv
// rtl/vga_term_writer.sv - character-cell writer for a text-mode VGA frame memory
// Accepts characters, handles control codes, and sweeps rows or the whole screen with blanks.
module vga_term_writer #(
  parameter int ROWS = 30,
  parameter int COLS = 70
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_ascii,
  input  logic [2:0] in_fg,
  input  logic [2:0] in_bg,
  output logic       we,
  output logic [4:0] wr_addr,
  output logic [6:0] wc_addr,
  output logic [7:0] w_ascii,
  output logic [2:0] w_fg_color,
  output logic [2:0] w_bg_color,
  output logic [4:0] cur_row,
  output logic [6:0] cur_col,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CLEAR, CLRROW} state_t;

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [7:0] BLANK    = 8'h20;

  state_t     state_q, state_d;
  logic [4:0] cur_row_q, cur_row_d;
  logic [6:0] cur_col_q, cur_col_d;
  logic [4:0] sw_row_q, sw_row_d;
  logic [6:0] sw_col_q, sw_col_d;
  logic [2:0] fg_q, fg_d;
  logic [2:0] bg_q, bg_d;
  logic       we_q, we_d;
  logic [4:0] wr_addr_q, wr_addr_d;
  logic [6:0] wc_addr_q, wc_addr_d;
  logic [7:0] w_ascii_q, w_ascii_d;
  logic [2:0] w_fg_q, w_fg_d;
  logic [2:0] w_bg_q, w_bg_d;

  logic       accept;
  logic       printable;
  logic [4:0] row_next;

  assign accept    = (state_q == IDLE) && in_valid;
  assign printable = (in_ascii >= 8'h20) && (in_ascii <= 8'h7E);
  assign row_next  = (cur_row_q == LAST_ROW) ? 5'd0 : cur_row_q + 5'd1;

  // State register; reset lands in CLEAR so the screen is blanked on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (printable && (cur_col_q == LAST_COL)) state_d = CLRROW;
          else if (in_ascii == 8'h0A)               state_d = CLRROW;
          else if (in_ascii == 8'h0C)               state_d = CLEAR;
        end
      end
      CLEAR: begin
        if ((sw_row_q == LAST_ROW) && (sw_col_q == LAST_COL)) state_d = IDLE;
      end
      CLRROW: begin
        if (sw_col_q == LAST_COL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    sw_row_d  = sw_row_q;
    sw_col_d  = sw_col_q;
    fg_d      = fg_q;
    bg_d      = bg_q;
    we_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wc_addr_d = wc_addr_q;
    w_ascii_d = w_ascii_q;
    w_fg_d    = w_fg_q;
    w_bg_d    = w_bg_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          fg_d     = in_fg;
          bg_d     = in_bg;
          sw_row_d = 5'd0;
          sw_col_d = 7'd0;
          if (printable) begin
            we_d      = 1'b1;
            wr_addr_d = cur_row_q;
            wc_addr_d = cur_col_q;
            w_ascii_d = in_ascii;
            w_fg_d    = in_fg;
            w_bg_d    = in_bg;
            if (cur_col_q == LAST_COL) begin
              cur_col_d = 7'd0;
              cur_row_d = row_next;
            end else begin
              cur_col_d = cur_col_q + 7'd1;
            end
          end else begin
            case (in_ascii)
              8'h0A: begin
                cur_col_d = 7'd0;
                cur_row_d = row_next;
              end
              8'h0D: cur_col_d = 7'd0;
              8'h08: begin
                if (cur_col_q != 7'd0) begin
                  cur_col_d = cur_col_q - 7'd1;
                  we_d      = 1'b1;
                  wr_addr_d = cur_row_q;
                  wc_addr_d = cur_col_q - 7'd1;
                  w_ascii_d = BLANK;
                  w_fg_d    = in_fg;
                  w_bg_d    = in_bg;
                end
              end
              8'h0C: begin
                cur_row_d = 5'd0;
                cur_col_d = 7'd0;
              end
              default: ;
            endcase
          end
        end
      end
      CLEAR: begin
        we_d      = 1'b1;
        wr_addr_d = sw_row_q;
        wc_addr_d = sw_col_q;
        w_ascii_d = BLANK;
        w_fg_d    = fg_q;
        w_bg_d    = bg_q;
        if (sw_col_q == LAST_COL) begin
          sw_col_d = 7'd0;
          sw_row_d = (sw_row_q == LAST_ROW) ? 5'd0 : sw_row_q + 5'd1;
        end else begin
          sw_col_d = sw_col_q + 7'd1;
        end
      end
      CLRROW: begin
        we_d      = 1'b1;
        wr_addr_d = cur_row_q;
        wc_addr_d = sw_col_q;
        w_ascii_d = BLANK;
        w_fg_d    = fg_q;
        w_bg_d    = bg_q;
        sw_col_d  = (sw_col_q == LAST_COL) ? 7'd0 : sw_col_q + 7'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_row_q <= 5'd0;
      cur_col_q <= 7'd0;
      sw_row_q  <= 5'd0;
      sw_col_q  <= 7'd0;
      fg_q      <= 3'd7;
      bg_q      <= 3'd0;
      we_q      <= 1'b0;
      wr_addr_q <= 5'd0;
      wc_addr_q <= 7'd0;
      w_ascii_q <= 8'd0;
      w_fg_q    <= 3'd0;
      w_bg_q    <= 3'd0;
    end else begin
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      sw_row_q  <= sw_row_d;
      sw_col_q  <= sw_col_d;
      fg_q      <= fg_d;
      bg_q      <= bg_d;
      we_q      <= we_d;
      wr_addr_q <= wr_addr_d;
      wc_addr_q <= wc_addr_d;
      w_ascii_q <= w_ascii_d;
      w_fg_q    <= w_fg_d;
      w_bg_q    <= w_bg_d;
    end
  end

  always_comb begin
    in_ready   = (state_q == IDLE);
    busy       = (state_q != IDLE);
    we         = we_q;
    wr_addr    = wr_addr_q;
    wc_addr    = wc_addr_q;
    w_ascii    = w_ascii_q;
    w_fg_color = w_fg_q;
    w_bg_color = w_bg_q;
    cur_row    = cur_row_q;
    cur_col    = cur_col_q;
  end

endmodule

// File: tb/tb_vga_term_writer.sv
// tb/tb_vga_term_writer.sv - randomized self-checking bench for vga_term_writer
// A cycle-tagged expected-write queue and cursor model are compared against the DUT every cycle.
module tb_vga_term_writer;

  localparam int ROWS = 30;
  localparam int COLS = 70;
  localparam int NCELL = ROWS * COLS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_ascii = 8'h00;
  logic [2:0] in_fg = 3'd0;
  logic [2:0] in_bg = 3'd0;
  logic       in_ready, we, busy;
  logic [4:0] wr_addr, cur_row;
  logic [6:0] wc_addr, cur_col;
  logic [7:0] w_ascii;
  logic [2:0] w_fg_color, w_bg_color;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int t;
    int row;
    int col;
    int ch;
    int fg;
    int bg;
  } wr_t;

  wr_t exp_q[$];
  int  m_row = 0;
  int  m_col = 0;
  int  idle_from = 1 << 30;
  bit  prev_rst = 1'b1;

  vga_term_writer #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ascii(in_ascii),
    .in_fg(in_fg), .in_bg(in_bg),
    .we(we), .wr_addr(wr_addr), .wc_addr(wc_addr), .w_ascii(w_ascii),
    .w_fg_color(w_fg_color), .w_bg_color(w_bg_color),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void push(input int t, input int r, input int c, input int ch,
                               input int fg, input int bg);
    wr_t w;
    w.t = t; w.row = r; w.col = c; w.ch = ch; w.fg = fg; w.bg = bg;
    exp_q.push_back(w);
  endfunction

  // Effect of a character accepted on edge t; its writes start in cycle t.
  function automatic void model_accept(input int t, input int a, input int fg, input int bg);
    idle_from = t;
    if (a >= 8'h20 && a <= 8'h7E) begin
      push(t, m_row, m_col, a, fg, bg);
      if (m_col == COLS - 1) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        for (int i = 0; i < COLS; i++) push(t + 1 + i, m_row, i, 8'h20, fg, bg);
        idle_from = t + COLS;
      end else begin
        m_col++;
      end
    end else if (a == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
      for (int i = 0; i < COLS; i++) push(t + 1 + i, m_row, i, 8'h20, fg, bg);
      idle_from = t + COLS;
    end else if (a == 8'h0D) begin
      m_col = 0;
    end else if (a == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        push(t, m_row, m_col, 8'h20, fg, bg);
      end
    end else if (a == 8'h0C) begin
      m_row = 0;
      m_col = 0;
      for (int k = 0; k < NCELL; k++) push(t + 1 + k, k / COLS, k % COLS, 8'h20, fg, bg);
      idle_from = t + NCELL;
    end
  endfunction

  always @(negedge clk) begin : compare
    bit  ew;
    bit  exp_rdy;
    wr_t w;
    if (rst) begin
      check("reset_outputs",
            {in_ready, we, wr_addr, wc_addr, w_ascii, w_fg_color, w_bg_color, cur_row, cur_col},
            64'd0);
      exp_q.delete();
      m_row = 0;
      m_col = 0;
      idle_from = 1 << 30;
      prev_rst = 1'b1;
    end else begin
      ew = (exp_q.size() > 0) && (exp_q[0].t == cyc);
      exp_rdy = (cyc >= idle_from);
      check("control", {in_ready, busy, we, cur_row, cur_col},
            {exp_rdy, !exp_rdy, ew, 5'(m_row), 7'(m_col)});
      if (ew) begin
        w = exp_q.pop_front();
        check("write_cell", {wr_addr, wc_addr, w_ascii, w_fg_color, w_bg_color},
              {5'(w.row), 7'(w.col), 8'(w.ch), 3'(w.fg), 3'(w.bg)});
      end
      check("addr_range", {(wr_addr < ROWS), (wc_addr < COLS)}, 2'b11);
      if (prev_rst) begin
        for (int k = 0; k < NCELL; k++) push(cyc + 1 + k, k / COLS, k % COLS, 8'h20, 7, 0);
        idle_from = cyc + NCELL;
        prev_rst = 1'b0;
      end
      if (in_valid && in_ready) model_accept(cyc + 1, in_ascii, in_fg, in_bg);
    end
  end

  task automatic send(input logic [7:0] a, input logic [2:0] f, input logic [2:0] b);
    int k;
    k = 0;
    in_valid = 1'b1; in_ascii = a; in_fg = f; in_bg = b;
    @(negedge clk);
    while (!in_ready && k < 5000) begin
      k++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("handshake_timeout", in_ready, 1'b1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(output int n_we, output int n_busy);
    int k;
    k = 0; n_we = 0; n_busy = 0;
    @(negedge clk);
    while (!in_ready && k < 5000) begin
      if (we) n_we++;
      n_busy++;
      k++;
      @(negedge clk);
    end
    if (we) n_we++;
    check("idle_reached", in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_print();
    return 8'($urandom_range(8'h20, 8'h7E));
  endfunction

  function automatic logic [7:0] rand_other();
    logic [7:0] tbl [7];
    tbl = '{8'h00, 8'h01, 8'h07, 8'h09, 8'h0B, 8'h1B, 8'h1F};
    if ($urandom_range(0, 1) == 0) return 8'(8'h7F + $urandom_range(0, 128));
    return tbl[$urandom_range(0, 6)];
  endfunction

  initial begin
    int nw, nb, r;
    logic [7:0] ch;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_idle(nw, nb);
    check("boot_clear_writes", nw, 2100);
    check("boot_clear_busy", nb, 2100);
    check("boot_cursor", {cur_row, cur_col}, 12'd0);

    send(8'h41, 3'd2, 3'd1);
    send(8'h42, 3'd2, 3'd1);
    wait_idle(nw, nb);
    check("ab_cursor", {cur_row, cur_col}, {5'd0, 7'd2});
    check("ab_writes_seen", nw, 1);

    send(8'h0D, 3'd3, 3'd4);
    repeat (29) send(8'h0A, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    repeat (69) send(rand_print(), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    check("corner_cursor", {cur_row, cur_col}, {5'd29, 7'd69});
    send(8'h5A, 3'd6, 3'd3);
    wait_idle(nw, nb);
    check("wrap_busy_cycles", nb, 70);
    check("wrap_writes", nw, 71);
    check("wrap_cursor", {cur_row, cur_col}, 12'd0);

    repeat (5) send(8'h0A, 3'd1, 3'd0);
    repeat (10) send(rand_print(), 3'd4, 3'd5);
    send(8'h0D, 3'd2, 3'd2);
    send(8'h08, 3'd2, 3'd2);
    check("cr_bs_cursor", {cur_row, cur_col}, {5'd5, 7'd0});
    send(8'h0A, 3'd5, 3'd6);
    wait_idle(nw, nb);
    check("lf_writes", nw, 70);
    check("lf_cursor", {cur_row, cur_col}, {5'd6, 7'd0});

    repeat (27) send(8'h0A, 3'd7, 3'd1);
    repeat (4) send(rand_print(), 3'd3, 3'd3);
    send(8'h08, 3'd1, 3'd6);
    wait_idle(nw, nb);
    check("bs_writes", nw, 1);
    check("bs_cursor", {cur_row, cur_col}, {5'd3, 7'd3});

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      ch = rand_print();
      else if (r < 78) ch = 8'h0A;
      else if (r < 83) ch = 8'h0D;
      else if (r < 90) ch = 8'h08;
      else if (r < 91) ch = 8'h0C;
      else             ch = rand_other();
      send(ch, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    wait_idle(nw, nb);

    send(8'h0C, 3'd5, 3'd2);
    repeat (500) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_we", {we, in_ready}, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_idle(nw, nb);
    check("reclear_writes", nw, 2100);
    check("reclear_cursor", {cur_row, cur_col}, 12'd0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
